// File: rtl/pcie_flow_pkg.sv
// Shared definitions for the PCIe flow-control FSM.
//   - state encodings (state_e)
//   - default channel count / occupancy width
//   - get_count(): extracts one channel's occupancy from a packed vector
package pcie_flow_pkg;

  localparam int unsigned NUM_CH_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 4;

  // Upper bounds used to size the unpacking helper's argument.
  localparam int unsigned MAX_CH   = 32;
  localparam int unsigned MAX_W    = 32;
  localparam int unsigned MAX_BITS = MAX_CH * MAX_W;

  typedef enum logic [2:0] {
    ST_RESET  = 3'b000,
    ST_INIT   = 3'b001,
    ST_IDLE   = 3'b010,
    ST_ERROR  = 3'b011,
    ST_ACTIVE = 3'b100
  } state_e;

  // Returns channel i (width w) of a zero-extended packed occupancy vector.
  function automatic logic [31:0] get_count(
    input logic [MAX_BITS-1:0] vec,
    input int unsigned         i,
    input int unsigned         w
  );
    logic [MAX_BITS-1:0] shifted;
    logic [31:0]         mask;
    shifted = vec >> (i * w);
    mask    = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/pcie_ch_thresh.sv
// Per-channel threshold comparator.
//   count        : channel occupancy
//   umbral_L_out : latched low threshold
//   umbral_H_out : latched high threshold
//   enable       : flags are forced low when deasserted
//   almost_full  : count >= high threshold (gated by enable)
//   almost_empty : count <= low threshold (gated by enable)
//   below_low    : count <= low threshold (ungated, used for pause release)
module pcie_ch_thresh #(
  parameter int unsigned CNT_W = 4
) (
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] umbral_L_out,
  input  logic [CNT_W-1:0] umbral_H_out,
  input  logic             enable,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             below_low
);

  always_comb begin
    below_low    = (count <= umbral_L_out);
    almost_full  = enable && (count >= umbral_H_out);
    almost_empty = enable && below_low;
  end

endmodule

// File: rtl/pcie_flow_fsm.sv
// PCIe link flow-control FSM.
//   clk, reset_L        : clock, async active-low reset
//   init                : hold in INIT and load thresholds
//   umbral_L/umbral_H   : low/high threshold inputs
//   fifo_count          : packed per-channel occupancies
//   fifo_err            : per-channel overflow/underflow pulse
//   state               : current state encoding
//   umbral_L_out/_H_out : latched thresholds
//   idle_out/active_out/error_out : registered state decodes
//   almost_full/almost_empty      : per-channel flags
//   err_ch              : sticky error channel mask
//   pause               : hysteretic backpressure to the arbiter
module pcie_flow_fsm
  import pcie_flow_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    init,
  input  logic [CNT_W-1:0]        umbral_L,
  input  logic [CNT_W-1:0]        umbral_H,
  input  logic [NUM_CH*CNT_W-1:0] fifo_count,
  input  logic [NUM_CH-1:0]       fifo_err,
  output logic [2:0]              state,
  output logic [CNT_W-1:0]        umbral_L_out,
  output logic [CNT_W-1:0]        umbral_H_out,
  output logic                    idle_out,
  output logic                    active_out,
  output logic                    error_out,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH-1:0]       almost_empty,
  output logic [NUM_CH-1:0]       err_ch,
  output logic                    pause
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    thr_l_q, thr_l_d;
  logic [CNT_W-1:0]    thr_h_q, thr_h_d;
  logic [NUM_CH-1:0]   af_q, af_d;
  logic [NUM_CH-1:0]   ae_q, ae_d;
  logic [NUM_CH-1:0]   err_ch_q, err_ch_d;
  logic                pause_q, pause_d;
  logic                idle_q, idle_d;
  logic                active_q, active_d;
  logic                error_q, error_d;

  logic [NUM_CH-1:0]   below_low;
  logic                flag_en;
  logic [MAX_BITS-1:0] cnt_ext;

  always_comb begin
    cnt_ext = '0;
    cnt_ext[NUM_CH*CNT_W-1:0] = fifo_count;
  end

  // Flags reflect the state being entered, so they are enabled off state_d.
  assign flag_en = (state_d == ST_IDLE) || (state_d == ST_ACTIVE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_ch;
    assign cnt_ch = CNT_W'(get_count(cnt_ext, g, CNT_W));

    pcie_ch_thresh #(
      .CNT_W (CNT_W)
    ) u_thresh (
      .count        (cnt_ch),
      .umbral_L_out (thr_l_q),
      .umbral_H_out (thr_h_q),
      .enable       (flag_en),
      .almost_full  (af_d[g]),
      .almost_empty (ae_d[g]),
      .below_low    (below_low[g])
    );
  end

  always_comb begin
    state_d  = ST_RESET;
    thr_l_d  = thr_l_q;
    thr_h_d  = thr_h_q;
    err_ch_d = err_ch_q;

    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (init) begin
          state_d = ST_INIT;
          thr_l_d = umbral_L;
          thr_h_d = umbral_H;
        end else if (thr_l_q > thr_h_q) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE, ST_ACTIVE: begin
        if (init) begin
          state_d = ST_INIT;
        end else if (|fifo_err) begin
          state_d  = ST_ERROR;
          err_ch_d = err_ch_q | fifo_err;
        end else if (fifo_count == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ERROR: begin
        if (init) begin
          state_d = ST_INIT;
        end else begin
          state_d  = ST_ERROR;
          err_ch_d = err_ch_q | fifo_err;
        end
      end
      default: state_d = ST_RESET;
    endcase

    // Entering INIT always wipes the error mask, even if fifo_err is active.
    if (state_d == ST_INIT) begin
      err_ch_d = '0;
    end

    // Pause sets on any almost-full, releases only once every channel is at
    // or below the low threshold, and otherwise holds (hysteresis).
    case (state_d)
      ST_IDLE, ST_ACTIVE: begin
        if (|af_d) begin
          pause_d = 1'b1;
        end else if (&below_low) begin
          pause_d = 1'b0;
        end else begin
          pause_d = pause_q;
        end
      end
      ST_ERROR: pause_d = 1'b1;
      default:  pause_d = 1'b0;
    endcase

    idle_d   = (state_d == ST_IDLE);
    active_d = (state_d == ST_ACTIVE);
    error_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_RESET;
      thr_l_q  <= '0;
      thr_h_q  <= '0;
      af_q     <= '0;
      ae_q     <= '0;
      err_ch_q <= '0;
      pause_q  <= 1'b0;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      thr_l_q  <= thr_l_d;
      thr_h_q  <= thr_h_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      err_ch_q <= err_ch_d;
      pause_q  <= pause_d;
      idle_q   <= idle_d;
      active_q <= active_d;
      error_q  <= error_d;
    end
  end

  assign state        = state_q;
  assign umbral_L_out = thr_l_q;
  assign umbral_H_out = thr_h_q;
  assign idle_out     = idle_q;
  assign active_out   = active_q;
  assign error_out    = error_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign err_ch       = err_ch_q;
  assign pause        = pause_q;

endmodule

// File: tb/tb_pcie_flow_fsm.sv
module tb_pcie_flow_fsm;

  logic        clk;
  logic        reset_L;
  logic        init;
  logic [3:0]  umbral_L, umbral_H;
  logic [31:0] fifo_count;
  logic [7:0]  fifo_err;
  logic [2:0]  state;
  logic [3:0]  umbral_L_out, umbral_H_out;
  logic        idle_out, active_out, error_out;
  logic [7:0]  almost_full, almost_empty, err_ch;
  logic        pause;

  int n_checks = 0;
  int n_fail   = 0;

  pcie_flow_fsm #(
    .NUM_CH (8),
    .CNT_W  (4)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .umbral_L     (umbral_L),
    .umbral_H     (umbral_H),
    .fifo_count   (fifo_count),
    .fifo_err     (fifo_err),
    .state        (state),
    .umbral_L_out (umbral_L_out),
    .umbral_H_out (umbral_H_out),
    .idle_out     (idle_out),
    .active_out   (active_out),
    .error_out    (error_out),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .err_ch       (err_ch),
    .pause        (pause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        init;
    logic [3:0]  ul, uh;
    logic [31:0] cnt;
    logic [7:0]  err;
    logic [2:0]  st;
    logic [3:0]  eul, euh;
    logic [7:0]  af, ae, ech;
    logic        pause;
  } vec_t;

  typedef struct {
    int          idx;
    logic [2:0]  st;
    logic [3:0]  eul, euh;
    logic [7:0]  af, ae, ech;
    logic        pause;
  } exp_t;

  vec_t vt[22];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"}, 32'(state), 32'd0);
    check({tag, " thr"}, {24'd0, umbral_L_out, umbral_H_out}, 32'd0);
    check({tag, " decodes"}, {29'd0, idle_out, active_out, error_out}, 32'd0);
    check({tag, " flags"}, {16'd0, almost_full, almost_empty}, 32'd0);
    check({tag, " err_ch"}, 32'(err_ch), 32'd0);
    check({tag, " pause"}, 32'(pause), 32'd0);
  endtask

  task automatic pop_and_compare();
    exp_t e;
    string t;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: no expected entry, got state %0h", state);
      return;
    end
    e = sb.pop_front();
    t = $sformatf("v%0d", e.idx);
    check({t, " state"}, 32'(state), 32'(e.st));
    check({t, " umbral_L_out"}, 32'(umbral_L_out), 32'(e.eul));
    check({t, " umbral_H_out"}, 32'(umbral_H_out), 32'(e.euh));
    check({t, " decodes"}, {29'd0, idle_out, active_out, error_out},
          {29'd0, e.st == 3'd2, e.st == 3'd4, e.st == 3'd3});
    check({t, " almost_full"}, 32'(almost_full), 32'(e.af));
    check({t, " almost_empty"}, 32'(almost_empty), 32'(e.ae));
    check({t, " err_ch"}, 32'(err_ch), 32'(e.ech));
    check({t, " pause"}, 32'(pause), 32'(e.pause));
  endtask

  initial begin
    //            init ul  uh  cnt            err    st    eul euh af     ae     ech    pause
    vt[0]  = '{1'b1, 2,  12, 32'h0,         8'h00, 3'd1, 0,  0,  8'h00, 8'h00, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 2,  12, 32'h0,         8'h00, 3'd1, 2,  12, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[2]  = '{1'b0, 2,  12, 32'h0,         8'h00, 3'd2, 2,  12, 8'h00, 8'hFF, 8'h00, 1'b0};
    vt[3]  = '{1'b0, 2,  12, 32'h0000_5000, 8'h00, 3'd4, 2,  12, 8'h00, 8'hF7, 8'h00, 1'b0};
    vt[4]  = '{1'b0, 2,  12, 32'h0,         8'h00, 3'd2, 2,  12, 8'h00, 8'hFF, 8'h00, 1'b0};
    vt[5]  = '{1'b0, 2,  12, 32'h0000_000C, 8'h00, 3'd4, 2,  12, 8'h01, 8'hFE, 8'h00, 1'b1};
    vt[6]  = '{1'b0, 2,  12, 32'h0000_0006, 8'h00, 3'd4, 2,  12, 8'h00, 8'hFE, 8'h00, 1'b1};
    vt[7]  = '{1'b0, 2,  12, 32'h0000_0002, 8'h00, 3'd4, 2,  12, 8'h00, 8'hFF, 8'h00, 1'b0};
    vt[8]  = '{1'b0, 2,  12, 32'h0000_0002, 8'h21, 3'd3, 2,  12, 8'h00, 8'h00, 8'h21, 1'b1};
    vt[9]  = '{1'b0, 2,  12, 32'h0000_0002, 8'h04, 3'd3, 2,  12, 8'h00, 8'h00, 8'h25, 1'b1};
    vt[10] = '{1'b0, 2,  12, 32'h0000_0002, 8'h00, 3'd3, 2,  12, 8'h00, 8'h00, 8'h25, 1'b1};
    vt[11] = '{1'b1, 2,  12, 32'h0000_0002, 8'h02, 3'd1, 2,  12, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[12] = '{1'b1, 9,  3,  32'h0000_0002, 8'h00, 3'd1, 9,  3,  8'h00, 8'h00, 8'h00, 1'b0};
    vt[13] = '{1'b0, 9,  3,  32'h0000_0002, 8'h00, 3'd3, 9,  3,  8'h00, 8'h00, 8'h00, 1'b1};
    vt[14] = '{1'b1, 9,  3,  32'h0000_0002, 8'h00, 3'd1, 9,  3,  8'h00, 8'h00, 8'h00, 1'b0};
    vt[15] = '{1'b1, 7,  7,  32'h0000_0002, 8'h00, 3'd1, 7,  7,  8'h00, 8'h00, 8'h00, 1'b0};
    vt[16] = '{1'b0, 7,  7,  32'h0000_00F7, 8'h00, 3'd2, 7,  7,  8'h03, 8'hFD, 8'h00, 1'b1};
    vt[17] = '{1'b0, 7,  7,  32'h0000_00F7, 8'h00, 3'd4, 7,  7,  8'h03, 8'hFD, 8'h00, 1'b1};
    vt[18] = '{1'b1, 7,  7,  32'h0000_00F7, 8'h10, 3'd1, 7,  7,  8'h00, 8'h00, 8'h00, 1'b0};
    vt[19] = '{1'b1, 2,  12, 32'h0000_000C, 8'h00, 3'd1, 2,  12, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[20] = '{1'b0, 2,  12, 32'h0000_000C, 8'h00, 3'd2, 2,  12, 8'h01, 8'hFE, 8'h00, 1'b1};
    vt[21] = '{1'b0, 2,  12, 32'h0000_000C, 8'h00, 3'd4, 2,  12, 8'h01, 8'hFE, 8'h00, 1'b1};

    reset_L    = 1'b1;
    init       = 1'b1;
    umbral_L   = 4'd2;
    umbral_H   = 4'd12;
    fifo_count = '0;
    fifo_err   = '0;

    // Power-up reset, asserted before the first edge and held across one.
    #2 reset_L = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk); #1;
    check_all_zero("reset_held");

    for (int i = 0; i < 22; i++) begin
      exp_t e;
      @(negedge clk);
      reset_L    = 1'b1;
      init       = vt[i].init;
      umbral_L   = vt[i].ul;
      umbral_H   = vt[i].uh;
      fifo_count = vt[i].cnt;
      fifo_err   = vt[i].err;
      e = '{i, vt[i].st, vt[i].eul, vt[i].euh, vt[i].af, vt[i].ae, vt[i].ech, vt[i].pause};
      sb.push_back(e);
      @(posedge clk); #1;
      pop_and_compare();
    end

    // Async reset between edges while ACTIVE with pause asserted.
    check("pre_reset active", {30'd0, active_out, pause}, 32'd3);
    #2 reset_L = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk); #1;
    check_all_zero("async_reset_held");

    // Release: first edge goes to INIT with thresholds still cleared,
    // the next loads the presented thresholds.
    @(negedge clk);
    reset_L    = 1'b1;
    init       = 1'b1;
    umbral_L   = 4'd5;
    umbral_H   = 4'd10;
    fifo_count = '0;
    fifo_err   = '0;
    @(posedge clk); #1;
    check("release state", 32'(state), 32'd1);
    check("release thr", {24'd0, umbral_L_out, umbral_H_out}, 32'h00);
    @(posedge clk); #1;
    check("release load", {24'd0, umbral_L_out, umbral_H_out}, 32'h5A);
    @(negedge clk);
    init = 1'b0;
    @(posedge clk); #1;
    check("release idle", {29'd0, idle_out, active_out, error_out}, 32'd4);
    check("release ae", 32'(almost_empty), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
